// File: rtl/ballot_pkg.sv
// ballot_pkg: shared session encodings and candidate helpers for the ballot booth arbiter
package ballot_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AUTH   = 3'd1,
        S_OPEN   = 3'd2,
        S_CLOSED = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    localparam int NUM_CANDIDATES = 5;

    localparam logic [2:0] CAND_A = 3'd0;
    localparam logic [2:0] CAND_B = 3'd1;
    localparam logic [2:0] CAND_C = 3'd2;
    localparam logic [2:0] CAND_D = 3'd3;
    localparam logic [2:0] CAND_E = 3'd4;

    function automatic logic [4:0] cand_onehot(input logic [2:0] idx);
        return (int'(idx) < NUM_CANDIDATES) ? 5'b00001 << idx : 5'b00000;
    endfunction

endpackage

// File: rtl/ballot_booth_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant starting after the last granted requester
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] elig_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] ptr_q;
    logic         found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(ptr_q) + k) % N;
            if (!found && elig_i[c]) begin
                found    = 1'b1;
                idx_o    = c[W-1:0];
                gnt_o[c] = 1'b1;
            end
        end
    end

    // pointer resets to the last booth so booth 0 is first in line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= W'(N - 1);
        else if (advance_i && found) ptr_q <= idx_o;
    end

endmodule

// File: rtl/ballot_booth_arbiter.sv
// ballot_booth_arbiter: election session FSM plus round-robin booth arbitration onto vote pulses
module ballot_booth_arbiter
    import ballot_pkg::*;
#(
    parameter int         N_BOOTHS  = 4,
    parameter logic [3:0] PASSWORD  = 4'b1010,
    parameter int         MAX_FAILS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  auth,
    input  logic [3:0]            password_in,
    input  logic                  end_voting,
    input  logic [N_BOOTHS-1:0]   booth_req,
    input  logic [3*N_BOOTHS-1:0] booth_cand,
    output logic [N_BOOTHS-1:0]   booth_ack,
    output logic [N_BOOTHS-1:0]   booth_reject,
    output logic                  vote_A,
    output logic                  vote_B,
    output logic                  vote_C,
    output logic                  vote_D,
    output logic                  vote_E,
    output logic                  clear_counts,
    output logic                  auth_ok,
    output logic                  auth_fail,
    output logic [2:0]            session_state,
    output logic [7:0]            total_votes
);

    localparam int W = $clog2(N_BOOTHS);

    state_t              state_q;
    logic [2:0]          fails_q;
    logic [7:0]          total_q;
    logic [N_BOOTHS-1:0] ack_q, rej_q, elig, gnt;
    logic [W-1:0]        gidx;
    logic [4:0]          vote_q;
    logic                clear_q, ok_q, fail_q, serve, accept, fwd;
    logic [2:0]          cand;

    // a booth whose ack/reject is still high has already been serviced
    assign elig   = booth_req & ~(ack_q | rej_q);
    assign serve  = (state_q == S_OPEN && !end_voting) || state_q == S_CLOSED || state_q == S_LOCKED;
    assign cand   = booth_cand[3*gidx +: 3];
    assign accept = state_q == S_OPEN && cand < 3'd5 && total_q != 8'hFF;
    assign fwd    = serve && accept && |gnt;

    rr_arbiter #(.N(N_BOOTHS)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .elig_i    (elig),
        .advance_i (serve),
        .gnt_o     (gnt),
        .idx_o     (gidx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fails_q <= '0;
            total_q <= '0;
            ack_q   <= '0;
            rej_q   <= '0;
            vote_q  <= '0;
            clear_q <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            ack_q   <= (serve && accept) ? gnt : '0;
            rej_q   <= (serve && !accept) ? gnt : '0;
            vote_q  <= fwd ? cand_onehot(cand) : 5'b0;
            clear_q <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            if (fwd) total_q <= total_q + 8'd1;
            case (state_q)
                S_IDLE: if (start) state_q <= S_AUTH;
                S_AUTH: if (auth) begin
                    if (password_in == PASSWORD) begin
                        ok_q    <= 1'b1;
                        fails_q <= '0;
                        state_q <= S_OPEN;
                    end else begin
                        fail_q  <= 1'b1;
                        fails_q <= fails_q + 3'd1;
                        if (fails_q == 3'(MAX_FAILS - 1)) state_q <= S_LOCKED;
                    end
                end
                S_OPEN: if (end_voting) state_q <= S_CLOSED;
                S_CLOSED: if (start) begin
                    state_q <= S_AUTH;
                    clear_q <= 1'b1;
                    total_q <= '0;
                    fails_q <= '0;
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign booth_ack     = ack_q;
    assign booth_reject  = rej_q;
    assign {vote_E, vote_D, vote_C, vote_B, vote_A} = vote_q;
    assign clear_counts  = clear_q;
    assign auth_ok       = ok_q;
    assign auth_fail     = fail_q;
    assign session_state = state_q;
    assign total_votes   = total_q;

endmodule

// File: tb/tb_ballot_booth_arbiter.sv
// tb_ballot_booth_arbiter: scoreboard bench for the ballot session controller and booth arbiter
module tb_ballot_booth_arbiter;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] rej;
        logic [4:0] vote;
        logic       ok;
        logic       fail;
        logic       clr;
        logic [2:0] st;
        logic [7:0] tot;
    } ev_t;

    logic        clk = 0, reset = 1, start = 0, auth = 0, end_voting = 0;
    logic [3:0]  password_in = 0, booth_req = 0, drop = 0;
    logic [11:0] booth_cand = 0;
    logic [3:0]  booth_ack, booth_reject;
    logic        vote_A, vote_B, vote_C, vote_D, vote_E;
    logic        clear_counts, auth_ok, auth_fail;
    logic [2:0]  session_state;
    logic [7:0]  total_votes;

    ev_t q[$];
    int  vectors = 0, errors = 0;

    ballot_booth_arbiter dut (
        .clk(clk), .reset(reset), .start(start), .auth(auth), .password_in(password_in),
        .end_voting(end_voting), .booth_req(booth_req), .booth_cand(booth_cand),
        .booth_ack(booth_ack), .booth_reject(booth_reject),
        .vote_A(vote_A), .vote_B(vote_B), .vote_C(vote_C), .vote_D(vote_D), .vote_E(vote_E),
        .clear_counts(clear_counts), .auth_ok(auth_ok), .auth_fail(auth_fail),
        .session_state(session_state), .total_votes(total_votes)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input logic [3:0] a, input logic [3:0] r, input logic [4:0] v,
                             input logic o, input logic f, input logic c,
                             input logic [2:0] s, input logic [7:0] t);
        q.push_back('{ack: a, rej: r, vote: v, ok: o, fail: f, clr: c, st: s, tot: t});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // booths drop their request one edge after seeing ack/reject
    task automatic tick();
        @(posedge clk);
        #1;
        booth_req = booth_req & ~drop;
        drop = booth_ack | booth_reject;
    endtask

    always @(negedge clk) begin
        ev_t got, e;
        got = '{ack: booth_ack, rej: booth_reject, vote: {vote_E, vote_D, vote_C, vote_B, vote_A},
                ok: auth_ok, fail: auth_fail, clr: clear_counts, st: session_state, tot: total_votes};
        if (!reset && (|got.ack || |got.rej || |got.vote || got.ok || got.fail || got.clr)) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", got);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", got, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("reset_state", {29'd0, session_state}, 32'd0);
        chk("reset_total", {24'd0, total_votes}, 32'd0);
        chk("reset_pulses", {18'd0, booth_ack, booth_reject, vote_A, vote_B, vote_C, vote_D, vote_E,
                             clear_counts, auth_ok, auth_fail}, 32'd0);

        start = 1; tick(); start = 0;
        chk("idle_to_auth", {29'd0, session_state}, 32'd1);
        expect_ev(0, 0, 0, 0, 1, 0, 3'd1, 0);
        password_in = 4'b0101; auth = 1; tick(); auth = 0;
        expect_ev(0, 0, 0, 1, 0, 0, 3'd2, 0);
        password_in = 4'b1010; auth = 1; tick(); auth = 0;
        tick();
        chk("auth_to_open", {29'd0, session_state}, 32'd2);

        booth_cand = {3'd0, 3'd2, 3'd1, 3'd0};
        expect_ev(4'b0001, 0, 5'b00001, 0, 0, 0, 3'd2, 1);
        expect_ev(4'b0010, 0, 5'b00010, 0, 0, 0, 3'd2, 2);
        expect_ev(4'b0100, 0, 5'b00100, 0, 0, 0, 3'd2, 3);
        expect_ev(4'b1000, 0, 5'b00001, 0, 0, 0, 3'd2, 4);
        booth_req = 4'b1111;
        repeat (6) tick();
        chk("total_after_four", {24'd0, total_votes}, 32'd4);

        booth_cand[8:6] = 3'd6;
        expect_ev(0, 4'b0100, 0, 0, 0, 0, 3'd2, 4);
        booth_req[2] = 1;
        repeat (3) tick();

        password_in = 4'b0101; auth = 1; start = 1; tick(); auth = 0; start = 0;
        chk("auth_ignored_open", {29'd0, session_state}, 32'd2);

        booth_cand[5:3] = 3'd0;
        booth_req[1] = 1; end_voting = 1; tick(); end_voting = 0;
        chk("end_voting_wins", {29'd0, session_state}, 32'd3);
        expect_ev(0, 4'b0010, 0, 0, 0, 0, 3'd3, 4);
        repeat (2) tick();
        expect_ev(0, 0, 0, 0, 0, 1, 3'd1, 0);
        start = 1; tick(); start = 0;
        chk("cleared_total", {24'd0, total_votes}, 32'd0);

        expect_ev(0, 0, 0, 1, 0, 0, 3'd2, 0);
        password_in = 4'b1010; auth = 1; tick(); auth = 0;
        for (int i = 0; i < 255; i++) begin
            booth_cand[2:0] = 3'(i % 5);
            expect_ev(4'b0001, 0, 5'b00001 << (i % 5), 0, 0, 0, 3'd2, 8'(i + 1));
            booth_req[0] = 1;
            repeat (2) tick();
        end
        chk("total_255", {24'd0, total_votes}, 32'd255);
        booth_cand[2:0] = 3'd1;
        expect_ev(0, 4'b0001, 0, 0, 0, 0, 3'd2, 8'd255);
        booth_req[0] = 1;
        repeat (3) tick();
        chk("total_saturated", {24'd0, total_votes}, 32'd255);

        reset = 1; #1 reset = 0;
        start = 1; tick(); start = 0;
        password_in = 4'b0000;
        expect_ev(0, 0, 0, 0, 1, 0, 3'd1, 0);
        expect_ev(0, 0, 0, 0, 1, 0, 3'd1, 0);
        expect_ev(0, 0, 0, 0, 1, 0, 3'd4, 0);
        repeat (3) begin auth = 1; tick(); end
        auth = 0;
        chk("locked", {29'd0, session_state}, 32'd4);
        password_in = 4'b1010; start = 1; auth = 1; tick(); start = 0; auth = 0;
        tick();
        chk("locked_sticky", {29'd0, session_state}, 32'd4);
        booth_cand[11:9] = 3'd0;
        expect_ev(0, 4'b1000, 0, 0, 0, 0, 3'd4, 0);
        booth_req[3] = 1;
        repeat (3) tick();

        booth_req[0] = 1; tick();
        chk("reject_before_reset", {28'd0, booth_reject}, 32'd1);
        reset = 1; #1;
        chk("reset_mid_pulse", {28'd0, booth_reject}, 32'd0);
        chk("reset_mid_state", {29'd0, session_state}, 32'd0);
        reset = 0;
        repeat (4) tick();

        while (q.size() != 0) begin
            ev_t e;
            e = q.pop_front();
            vectors++;
            errors++;
            $display("FAIL missing_event: got none expected %h", e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ballot_booth_arbiter.md
# ballot_booth_arbiter

Session controller and round-robin arbiter placed in front of the five-candidate vote-counting datapath. It runs the election session (start, password authentication with lockout, open, close), and lets several voting booths share the single counter. Each booth's request is turned into exactly one single-cycle vote pulse on `vote_A`..`vote_E`. Booths see a per-booth ack/reject handshake; the counter sees only clean, mutually exclusive pulses.

## Interface
Parameters:
- `N_BOOTHS`, 4: number of requesting booths (2..8).
- `PASSWORD`, 4'b1010: session authentication code.
- `MAX_FAILS`, 3: consecutive wrong passwords before lockout (1..7).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; returns all state and outputs to reset values.
- `start`  in  1  level sampled each cycle; opens authentication (IDLE/CLOSED).
- `auth`  in  1  password strobe, one cycle.
- `password_in`  in  4  compared when `auth`=1.
- `end_voting`  in  1  closes an OPEN session.
- `booth_req`  in  N_BOOTHS  per-booth vote request, held until ack/reject.
- `booth_cand`  in  3*N_BOOTHS  candidate index per booth (0=A..4=E), stable while req.
- `booth_ack`  out  N_BOOTHS  one-cycle accept pulse.
- `booth_reject`  out  N_BOOTHS  one-cycle reject pulse.
- `vote_A`..`vote_E`  out  1 each  one-cycle vote pulse to counter; at most one high.
- `clear_counts`  out  1  one-cycle pulse to counter on a new session.
- `auth_ok`, `auth_fail`  out  1 each  one-cycle authentication result pulses.
- `session_state`  out  3  encoded FSM state.
- `total_votes`  out  8  votes forwarded this session, saturating.

## Operation
- States: IDLE=0, AUTH=1, OPEN=2, CLOSED=3, LOCKED=4.
- IDLE --start--> AUTH.
- CLOSED --start--> AUTH. The same edge also pulses `clear_counts`, clears `total_votes` and clears the fail count.
- AUTH, `auth`=1:
  - `password_in`==PASSWORD: pulse `auth_ok`, clear fail count, go to OPEN.
  - Otherwise: pulse `auth_fail` and increment fail count. When the count reaches MAX_FAILS, go to LOCKED.
- `auth` is ignored outside AUTH: no pulse is produced.
- OPEN --end_voting--> CLOSED.
- LOCKED is exited only by `reset`.
- Arbitration in OPEN:
  - Eligible booths are those with `booth_req`=1 and no ack/reject currently high.
  - At most one eligible booth is serviced per cycle.
  - Priority is round-robin, starting at the booth after the last serviced booth. The pointer resets to booth N_BOOTHS-1, so booth 0 wins first.
  - Serviced booth with cand ≤4 and `total_votes`<255: pulse `booth_ack` and the matching `vote_X`, and increment `total_votes`.
  - Serviced booth with cand ≥5, or `total_votes`==255: pulse `booth_reject` only. The pointer still advances.
- IDLE/AUTH: requests stay pending (no ack, no reject).
- CLOSED/LOCKED: one pending booth per cycle is rejected, round-robin order.
- `end_voting` in the same cycle as an eligible request: the close wins, no vote is forwarded, and the request is rejected later in CLOSED.
- `start` in the same cycle as `auth` in CLOSED: only `start` acts.
- `reset` mid-handshake: all pulses drop immediately, and the booth must re-request.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, `session_state`=IDLE, fail count 0.
- Latency: request sampled at edge k → ack/reject and `vote_X` are high for the cycle after edge k (one-cycle pulse).
- The booth drops `booth_req` at the edge after it sees ack/reject. The masking rule prevents a double grant.
- `auth_ok`/`auth_fail`/`clear_counts` go high one cycle after the sampling edge and last one cycle.
- Sustained throughput: one vote per cycle across booths, one vote per 2 cycles per booth.

## Structure
- Package `ballot_pkg` holds:
  - State encodings.
  - `NUM_CANDIDATES`=5.
  - Candidate index localparams.
  - A function converting index to 5-bit one-hot (all zero for invalid index).
- Sub-module `rr_arbiter`:
  - Parameterised width.
  - Inputs: eligible vector and `advance` enable. Outputs: one-hot grant and grant index.
  - Holds the last-grant pointer.

## Test plan
- Reset, start, `auth` with 4'b0101, then `auth` with 4'b1010 → `auth_fail` pulse, then `auth_ok` pulse; state goes AUTH→OPEN.
- Three consecutive wrong passwords → three `auth_fail` pulses, then state LOCKED. `start`/`auth` have no effect until `reset`.
- OPEN, booths 0..3 request at once with cands 0,1,2,0 → acks on booths 0,1,2,3 on consecutive cycles. Vote pulses are A,B,C,A, and `total_votes`=4.
- Booth 2 with cand 6 → `booth_reject`[2] only, no vote pulse, `total_votes` unchanged.
- `end_voting` in the same cycle as booth 1's request → state CLOSED, then `booth_reject`[1] the next cycle, no vote pulse. Then `start` → `clear_counts` pulse and `total_votes`=0.
- Force 255 accepted votes, then one more request → reject; `total_votes` stays 255.
